// File: rtl/ht_search_engine.sv
// ht_search_engine: consumer end of the hash-table request path.
// Takes one search request at a time (key, bucket, head pointer), walks the
// bucket's linked list through a 1-cycle-latency data-table read port and
// returns FOUND / NOT_FOUND / CHAIN_LIMIT / BAD_CMD with the matching value.
//
// Optional build macro: HT_SEARCH_STATS_EN adds saturating search/found
// counters and a max-hop tracker on stat_* outputs.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready high, waiting for a request
// RD    | read strobe on the data table for the current chain pointer
// CMP   | read data valid; compare key and decide the next step
// DONE  | result held on res_* until res_valid_o && res_ready_i

module ht_search_engine #(
  parameter int KEY_WIDTH      = 16,
  parameter int VALUE_WIDTH    = 16,
  parameter int HEAD_PTR_WIDTH = 4,
  parameter int BUCKET_WIDTH   = 4,
  parameter int MAX_CHAIN_LEN  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // request side (slave end of the hash-table request interface)
  input  logic [KEY_WIDTH-1:0]      ht_in_key,
  input  logic [VALUE_WIDTH-1:0]    ht_in_value,
  input  logic [1:0]                ht_in_cmd,
  input  logic [BUCKET_WIDTH-1:0]   ht_in_bucket,
  input  logic [HEAD_PTR_WIDTH-1:0] ht_in_head_ptr,
  input  logic                      ht_in_head_ptr_val,
  input  logic                      ht_in_valid,
  output logic                      ht_in_ready,
  // data-table read port
  output logic                      rd_en_o,
  output logic [HEAD_PTR_WIDTH-1:0] rd_addr_o,
  input  logic [KEY_WIDTH-1:0]      rd_key_i,
  input  logic [VALUE_WIDTH-1:0]    rd_value_i,
  input  logic [HEAD_PTR_WIDTH-1:0] rd_next_ptr_i,
  input  logic                      rd_next_ptr_val_i,
  // result side
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [1:0]                res_rc_o,
  output logic [KEY_WIDTH-1:0]      res_key_o,
  output logic [BUCKET_WIDTH-1:0]   res_bucket_o,
  output logic [VALUE_WIDTH-1:0]    res_value_o
`ifdef HT_SEARCH_STATS_EN
  ,
  output logic [31:0]               stat_search_cnt_o,
  output logic [31:0]               stat_found_cnt_o,
  output logic [7:0]                stat_max_hops_o
`endif
);

  localparam logic [1:0] CMD_SEARCH     = 2'd0;

  localparam logic [1:0] RC_FOUND       = 2'd0;
  localparam logic [1:0] RC_NOT_FOUND   = 2'd1;
  localparam logic [1:0] RC_CHAIN_LIMIT = 2'd2;
  localparam logic [1:0] RC_BAD_CMD     = 2'd3;

  localparam int HOP_W = $clog2(MAX_CHAIN_LEN + 1);
  localparam logic [HOP_W-1:0] HOP_MAX = HOP_W'(MAX_CHAIN_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [KEY_WIDTH-1:0]    key_q;
  logic [BUCKET_WIDTH-1:0] bucket_q;
  logic [1:0]              cmd_q;
  logic [HOP_W-1:0]        hops_q;

  // decisions made by the next-state logic and consumed by the datapath
  logic                    accept;
  logic                    finish;
  logic [1:0]              finish_rc;
  logic [VALUE_WIDTH-1:0]  finish_value;
  logic                    advance;
  logic                    res_hs;

  // the request payload value is not needed for a search
  logic unused_value;
  assign unused_value = ^ht_in_value;

  assign ht_in_ready = (state_q == IDLE) && !rst_i;
  assign res_hs      = res_valid_o && res_ready_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode and walk decisions
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    finish       = 1'b0;
    finish_rc    = RC_NOT_FOUND;
    finish_value = '0;
    advance      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ht_in_valid && ht_in_ready) begin
          accept = 1'b1;
          if (ht_in_cmd != CMD_SEARCH) begin
            state_d   = DONE;
            finish    = 1'b1;
            finish_rc = RC_BAD_CMD;
          end else if (!ht_in_head_ptr_val) begin
            state_d   = DONE;
            finish    = 1'b1;
            finish_rc = RC_NOT_FOUND;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = CMP;
      end
      CMP: begin
        if (rd_key_i == key_q) begin
          state_d      = DONE;
          finish       = 1'b1;
          finish_rc    = RC_FOUND;
          finish_value = rd_value_i;
        end else if (!rd_next_ptr_val_i) begin
          state_d   = DONE;
          finish    = 1'b1;
          finish_rc = RC_NOT_FOUND;
        end else if (hops_q == HOP_MAX) begin
          // hops_q already counts the read just completed
          state_d   = DONE;
          finish    = 1'b1;
          finish_rc = RC_CHAIN_LIMIT;
        end else begin
          state_d = RD;
          advance = 1'b1;
        end
      end
      DONE: begin
        if (res_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // request latch, hop counter and read port; rd_addr_o doubles as the
  // current chain pointer so it simply holds between reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_q     <= '0;
      bucket_q  <= '0;
      cmd_q     <= '0;
      hops_q    <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
    end else begin
      rd_en_o <= (state_d == RD);
      if (accept) begin
        key_q     <= ht_in_key;
        bucket_q  <= ht_in_bucket;
        cmd_q     <= ht_in_cmd;
        hops_q    <= '0;
        rd_addr_o <= ht_in_head_ptr;
      end else if (advance) begin
        rd_addr_o <= rd_next_ptr_i;
      end
      if ((state_q == RD) && (hops_q != HOP_MAX)) begin
        hops_q <= hops_q + 1'b1;
      end
    end
  end

  // result register: loaded once on entry to DONE, held until the handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_o  <= 1'b0;
      res_rc_o     <= '0;
      res_key_o    <= '0;
      res_bucket_o <= '0;
      res_value_o  <= '0;
    end else if (finish) begin
      res_valid_o  <= 1'b1;
      res_rc_o     <= finish_rc;
      res_value_o  <= finish_value;
      res_key_o    <= accept ? ht_in_key : key_q;
      res_bucket_o <= accept ? ht_in_bucket : bucket_q;
    end else if (res_hs) begin
      res_valid_o <= 1'b0;
    end
  end

`ifdef HT_SEARCH_STATS_EN
  logic [7:0] hops8;

  if (HOP_W <= 8) begin : g_hops_narrow
    assign hops8 = 8'(hops_q);
  end else begin : g_hops_wide
    assign hops8 = (hops_q > HOP_W'(255)) ? 8'hFF : hops_q[7:0];
  end

  // saturating statistics, updated when a result is consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_search_cnt_o <= '0;
      stat_found_cnt_o  <= '0;
      stat_max_hops_o   <= '0;
    end else if (res_hs) begin
      if ((cmd_q == CMD_SEARCH) && (stat_search_cnt_o != '1)) begin
        stat_search_cnt_o <= stat_search_cnt_o + 32'd1;
      end
      if ((res_rc_o == RC_FOUND) && (stat_found_cnt_o != '1)) begin
        stat_found_cnt_o <= stat_found_cnt_o + 32'd1;
      end
      if (hops8 > stat_max_hops_o) begin
        stat_max_hops_o <= hops8;
      end
    end
  end
`else
  // the latched command only feeds the statistics
  logic unused_cmd;
  assign unused_cmd = ^cmd_q;
`endif

endmodule

// File: tb/tb_ht_search_engine.sv
// Directed bench for ht_search_engine with a small data-table model.
module tb_ht_search_engine;

  localparam int KW = 16;
  localparam int VW = 16;
  localparam int PW = 4;
  localparam int BW = 4;

  localparam logic [1:0] CMD_SEARCH = 2'd0;
  localparam logic [1:0] CMD_INSERT = 2'd1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [KW-1:0] ht_in_key = '0;
  logic [VW-1:0] ht_in_value = '0;
  logic [1:0]    ht_in_cmd = '0;
  logic [BW-1:0] ht_in_bucket = '0;
  logic [PW-1:0] ht_in_head_ptr = '0;
  logic          ht_in_head_ptr_val = 1'b0;
  logic          ht_in_valid = 1'b0;
  logic          ht_in_ready;
  logic          rd_en_o;
  logic [PW-1:0] rd_addr_o;
  logic [KW-1:0] rd_key_i = '0;
  logic [VW-1:0] rd_value_i = '0;
  logic [PW-1:0] rd_next_ptr_i = '0;
  logic          rd_next_ptr_val_i = 1'b0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [1:0]    res_rc_o;
  logic [KW-1:0] res_key_o;
  logic [BW-1:0] res_bucket_o;
  logic [VW-1:0] res_value_o;
`ifdef HT_SEARCH_STATS_EN
  logic [31:0]   stat_search_cnt_o;
  logic [31:0]   stat_found_cnt_o;
  logic [7:0]    stat_max_hops_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [KW-1:0] mem_key  [16];
  logic [VW-1:0] mem_val  [16];
  logic [PW-1:0] mem_next [16];
  logic          mem_nv   [16];
  logic [PW-1:0] rd_log[$];

  ht_search_engine #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .HEAD_PTR_WIDTH(PW),
    .BUCKET_WIDTH(BW), .MAX_CHAIN_LEN(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ht_in_key(ht_in_key), .ht_in_value(ht_in_value), .ht_in_cmd(ht_in_cmd),
    .ht_in_bucket(ht_in_bucket), .ht_in_head_ptr(ht_in_head_ptr),
    .ht_in_head_ptr_val(ht_in_head_ptr_val), .ht_in_valid(ht_in_valid),
    .ht_in_ready(ht_in_ready),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_key_i(rd_key_i),
    .rd_value_i(rd_value_i), .rd_next_ptr_i(rd_next_ptr_i),
    .rd_next_ptr_val_i(rd_next_ptr_val_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_rc_o(res_rc_o),
    .res_key_o(res_key_o), .res_bucket_o(res_bucket_o), .res_value_o(res_value_o)
`ifdef HT_SEARCH_STATS_EN
    ,
    .stat_search_cnt_o(stat_search_cnt_o), .stat_found_cnt_o(stat_found_cnt_o),
    .stat_max_hops_o(stat_max_hops_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // data table: 1-cycle read latency, every read address logged
  always @(posedge clk_i) begin
    if (rd_en_o) begin
      rd_key_i          <= mem_key[rd_addr_o];
      rd_value_i        <= mem_val[rd_addr_o];
      rd_next_ptr_i     <= mem_next[rd_addr_o];
      rd_next_ptr_val_i <= mem_nv[rd_addr_o];
      rd_log.push_back(rd_addr_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int a, input logic [KW-1:0] k, input logic [VW-1:0] v,
                           input logic [PW-1:0] nx, input logic nv);
    mem_key[a] = k; mem_val[a] = v; mem_next[a] = nx; mem_nv[a] = nv;
  endtask

  // present a request, count edges from acceptance until res_valid_o
  task automatic send(input logic [1:0] cmd, input logic [KW-1:0] key,
                      input logic [BW-1:0] bkt, input logic [PW-1:0] head,
                      input logic hv, output int lat);
    rd_log.delete();
    @(negedge clk_i);
    ht_in_cmd = cmd; ht_in_key = key; ht_in_bucket = bkt;
    ht_in_head_ptr = head; ht_in_head_ptr_val = hv; ht_in_value = 16'h5A5A;
    ht_in_valid = 1'b1;
    chk("ready_idle", ht_in_ready, 1'b1);
    @(posedge clk_i); #1;
    ht_in_valid = 1'b0;
    lat = 1;
    while (!res_valid_o && lat < 64) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("res_valid_seen", res_valid_o, 1'b1);
  endtask

  // consume the result; no new accept possible in the handshake cycle
  task automatic consume;
    @(negedge clk_i);
    res_ready_i = 1'b1;
    chk("ready_in_handshake", ht_in_ready, 1'b0);
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk("valid_drops", res_valid_o, 1'b0);
    chk("ready_after_hs", ht_in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int n_reads;
    for (int i = 0; i < 16; i++) set_entry(i, '0, '0, '0, 1'b0);

    // reset state
    #2;
    chk("rst_ready", ht_in_ready, 1'b0);
    chk("rst_valid", res_valid_o, 1'b0);
    chk("rst_rd_en", rd_en_o, 1'b0);
    chk("rst_rd_addr", rd_addr_o, 0);
    chk("rst_rc", res_rc_o, 0);
    chk("rst_key", res_key_o, 0);
    chk("rst_value", res_value_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    #1 chk("ready_after_rst", ht_in_ready, 1'b1);

    // empty bucket
    send(CMD_SEARCH, 16'h1234, 4'd3, 4'd0, 1'b0, lat);
    chk("empty_lat", lat, 1);
    chk("empty_rc", res_rc_o, 2'd1);
    chk("empty_value", res_value_o, 0);
    chk("empty_key", res_key_o, 16'h1234);
    chk("empty_bucket", res_bucket_o, 4'd3);
    chk("empty_reads", rd_log.size(), 0);
    consume();

    // first-entry hit
    set_entry(5, 16'h1234, 16'hBEEF, 4'd0, 1'b0);
    send(CMD_SEARCH, 16'h1234, 4'd7, 4'd5, 1'b1, lat);
    chk("hit1_lat", lat, 3);
    chk("hit1_rc", res_rc_o, 2'd0);
    chk("hit1_value", res_value_o, 16'hBEEF);
    chk("hit1_bucket", res_bucket_o, 4'd7);
    chk("hit1_reads", rd_log.size(), 1);
    if (rd_log.size() > 0) chk("hit1_addr", rd_log[0], 4'd5);
    consume();

    // third-entry hit with result held back for 4 cycles
    set_entry(5, 16'h1111, 16'h0001, 4'd9, 1'b1);
    set_entry(9, 16'h2222, 16'h0002, 4'd2, 1'b1);
    set_entry(2, 16'h1234, 16'hCAFE, 4'd0, 1'b0);
    send(CMD_SEARCH, 16'h1234, 4'd1, 4'd5, 1'b1, lat);
    chk("hit3_lat", lat, 7);
    chk("hit3_reads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("hit3_addr0", rd_log[0], 4'd5);
      chk("hit3_addr1", rd_log[1], 4'd9);
      chk("hit3_addr2", rd_log[2], 4'd2);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("hold_valid", res_valid_o, 1'b1);
      chk("hold_rc", res_rc_o, 2'd0);
      chk("hold_value", res_value_o, 16'hCAFE);
      chk("hold_key", res_key_o, 16'h1234);
      chk("hold_ready", ht_in_ready, 1'b0);
      chk("hold_rd_en", rd_en_o, 1'b0);
    end
    consume();

    // miss at end of a 3-entry chain
    send(CMD_SEARCH, 16'h5555, 4'd1, 4'd5, 1'b1, lat);
    chk("miss_lat", lat, 7);
    chk("miss_rc", res_rc_o, 2'd1);
    chk("miss_value", res_value_o, 0);
    chk("miss_reads", rd_log.size(), 3);
    consume();

    // self-loop chain hits the limit after exactly 8 reads
    set_entry(3, 16'hAAAA, 16'h0003, 4'd3, 1'b1);
    send(CMD_SEARCH, 16'h1234, 4'd2, 4'd3, 1'b1, lat);
    chk("limit_lat", lat, 17);
    chk("limit_rc", res_rc_o, 2'd2);
    chk("limit_value", res_value_o, 0);
    chk("limit_reads", rd_log.size(), 8);
    foreach (rd_log[i]) chk("limit_addr", rd_log[i], 4'd3);
    consume();

    // bad command, then a back-to-back request right after the handshake
    send(CMD_INSERT, 16'h4321, 4'd4, 4'd5, 1'b1, lat);
    chk("bad_lat", lat, 1);
    chk("bad_rc", res_rc_o, 2'd3);
    chk("bad_value", res_value_o, 0);
    chk("bad_reads", rd_log.size(), 0);
    consume();
    send(CMD_SEARCH, 16'h0042, 4'd6, 4'd0, 1'b0, lat);
    chk("b2b_lat", lat, 1);
    chk("b2b_rc", res_rc_o, 2'd1);
    chk("b2b_key", res_key_o, 16'h0042);
    consume();

    // reset during CMP of the second hop
    rd_log.delete();
    @(negedge clk_i);
    ht_in_cmd = CMD_SEARCH; ht_in_key = 16'h7777; ht_in_bucket = 4'd1;
    ht_in_head_ptr = 4'd5; ht_in_head_ptr_val = 1'b1; ht_in_valid = 1'b1;
    @(posedge clk_i); #1;
    ht_in_valid = 1'b0;
    chk("mid_rd1", rd_en_o, 1'b1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("mid_rd2", rd_en_o, 1'b1);
    chk("mid_rd2_addr", rd_addr_o, 4'd9);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", res_valid_o, 1'b0);
    chk("mid_rst_rd_en", rd_en_o, 1'b0);
    chk("mid_rst_ready", ht_in_ready, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    #1 chk("mid_ready", ht_in_ready, 1'b1);
    n_reads = rd_log.size();
    chk("mid_reads_before", n_reads, 2);
    repeat (5) @(posedge clk_i);
    #1;
    chk("mid_no_new_reads", rd_log.size(), 2);
    chk("mid_no_result", res_valid_o, 1'b0);
`ifdef HT_SEARCH_STATS_EN
    chk("stat_search_rst", stat_search_cnt_o, 0);
    chk("stat_found_rst", stat_found_cnt_o, 0);
    chk("stat_hops_rst", stat_max_hops_o, 0);
`endif
    set_entry(5, 16'h1234, 16'hBEEF, 4'd0, 1'b0);
    send(CMD_SEARCH, 16'h1234, 4'd7, 4'd5, 1'b1, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rc", res_rc_o, 2'd0);
    chk("post_rst_value", res_value_o, 16'hBEEF);
    consume();
`ifdef HT_SEARCH_STATS_EN
    chk("stat_search_one", stat_search_cnt_o, 1);
    chk("stat_found_one", stat_found_cnt_o, 1);
    chk("stat_hops_one", stat_max_hops_o, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ht_search_engine.md
Name: ht_search_engine

Overview:
- Consumer (slave) end of the hash-table request interface (ht_if.slave).
- Accepts a search request carrying key, bucket and head pointer, walks the bucket's linked list through a 1-cycle-latency data-table read port, and returns found/not-found plus value.
- Sits after the head-table stage, before the result mux.
- Handles one request at a time; back-pressures via ready.

Parameters:
- KEY_WIDTH, hash_table package, key width.
- VALUE_WIDTH, hash_table package, value width.
- HEAD_PTR_WIDTH, hash_table package, data-table address width.
- MAX_CHAIN_LEN, 8, maximum entries visited per search (1..2^HEAD_PTR_WIDTH).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- ht_in  slave  ht_if.slave  request: key, value (ignored), cmd, bucket, head_ptr, head_ptr_val, valid; ready driven here.
- rd_en_o  output  1  data-table read strobe.
- rd_addr_o  output  HEAD_PTR_WIDTH  data-table read address.
- rd_key_i  input  KEY_WIDTH  entry key, valid 1 cycle after rd_en_o.
- rd_value_i  input  VALUE_WIDTH  entry value.
- rd_next_ptr_i  input  HEAD_PTR_WIDTH  next entry pointer.
- rd_next_ptr_val_i  input  1  next pointer valid.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  result accepted.
- res_rc_o  output  2  0=FOUND, 1=NOT_FOUND, 2=CHAIN_LIMIT, 3=BAD_CMD.
- res_key_o  output  KEY_WIDTH  searched key, echoed.
- res_bucket_o  output  BUCKET_WIDTH  bucket, echoed.
- res_value_o  output  VALUE_WIDTH  value on FOUND, else 0.

Behaviour:
- States: IDLE, RD, CMP, DONE.
- ht_in.ready = (state==IDLE) && !rst_i, combinational. A request is accepted when valid && ready.
- Reset values: state IDLE; res_valid_o, rd_en_o, rd_addr_o, res_rc_o, res_key_o, res_bucket_o, res_value_o all 0; hop counter 0.
- Reset is honoured mid-walk or mid-DONE: the result is dropped and no read is issued after reset.
- IDLE, on accept (cycle T):
  - Latch key, bucket, cmd and head_ptr; clear the hop counter.
  - cmd != SEARCH: go to DONE with rc=BAD_CMD.
  - head_ptr_val=0: go to DONE with rc=NOT_FOUND.
  - Otherwise: go to RD with the address set to head_ptr.
- RD (one cycle):
  - Drive rd_en_o=1 and rd_addr_o=current pointer (registered outputs, so asserted in the RD cycle).
  - Increment the hop counter; go to CMP.
- CMP (read data valid this cycle):
  - rd_key_i == latched key: DONE, rc=FOUND, value=rd_value_i.
  - Else rd_next_ptr_val_i=0: DONE, rc=NOT_FOUND.
  - Else hops == MAX_CHAIN_LEN: DONE, rc=CHAIN_LIMIT.
  - Else pointer=rd_next_ptr_i; go to RD.
- DONE:
  - res_valid_o=1; all result fields are stable until res_valid_o && res_ready_i.
  - On that handshake: res_valid_o falls next cycle and the block returns to IDLE. A new request cannot be accepted in the same cycle the result is consumed.
- rd_en_o=0 in every state except RD; rd_addr_o holds its last value.
- Latency, accept cycle T to first res_valid_o:
  - BAD_CMD or empty bucket: T+1.
  - Entry n (1-based) matches: T+2n+1. First entry = T+3.
- Key comparison is full-width equality. The hop counter is $clog2(MAX_CHAIN_LEN+1) bits and never wraps.
- A self-loop chain (next_ptr == current) terminates with CHAIN_LIMIT after MAX_CHAIN_LEN reads.

Optional Feature:
- Macro: HT_SEARCH_STATS_EN.
- Defined: adds outputs stat_search_cnt_o (32), stat_found_cnt_o (32) and stat_max_hops_o (8).
  - Search and found counters increment on each result handshake whose cmd was SEARCH / whose rc was FOUND.
  - stat_max_hops_o tracks the maximum hop count seen.
  - All saturate (no wrap) and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Empty bucket: accept with head_ptr_val=0, key=0x1234 -> res_valid_o at T+1, rc=1, value=0, rd_en_o never asserted.
- First-entry hit: head_ptr=5; RAM[5] key=0x1234, value=0xBEEF -> one read at addr 5, rc=0, value=0xBEEF at T+3.
- Third-entry hit: chain 5->9->2, key match at 2 -> reads at 5, 9, 2; rc=0 at T+7. With res_ready_i held low 4 cycles, outputs stay stable and ready stays 0.
- Chain limit: MAX_CHAIN_LEN=8, self-loop at addr 3, no match -> exactly 8 reads, rc=2.
- Bad command: cmd=INSERT -> rc=3 at T+1, no reads. Back-to-back: the next request is accepted only the cycle after the result handshake.
- Reset mid-walk: assert rst_i in CMP of the 2nd hop -> res_valid_o, rd_en_o = 0 immediately; after release ready=1 and the next search completes normally; with HT_SEARCH_STATS_EN the counters read 0.
